window_max_4bit: RTL and testbench

Streaming maximum tracker for 4-bit unsigned samples. Accepts samples over a valid/ready handshake, compares each incoming sample against the stored running maximum using one instance of the existing `comparator_4bit` (incoming = a, stored = b), and after `WINDOW` samples presents the window maximum and its position on an output valid/ready handshake. It sits directly downstream of `comparator_4bit` and consumes its `a_greater_b` result as the update decision.

---
 rtl/window_max_4bit_pkg.sv | 16 +
 rtl/window_max_4bit_comparator.sv | 37 +++
 rtl/window_max_4bit.sv | 109 ++++++++++
 tb/tb_window_max_4bit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/window_max_4bit_pkg.sv
// window_max_4bit_pkg
// Shared definitions for the streaming window-maximum tracker:
//   state_t        - FSM state encoding (ST_ACCUM, ST_HOLD)
//   WINDOW_DEFAULT - default number of samples per window
//   SAMPLE_W       - sample width in bits
package window_max_4bit_pkg;

  localparam int unsigned WINDOW_DEFAULT = 8;
  localparam int unsigned SAMPLE_W       = 4;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

endpackage : window_max_4bit_pkg

// File: rtl/window_max_4bit_comparator.sv
// comparator_4bit
// Purely combinational 4-bit unsigned magnitude comparator.
// Ports:
//   a0..a3      in  bits of operand A (a0 = LSB)
//   b0..b3      in  bits of operand B (b0 = LSB)
//   a_greater_b out 1 when A > B (strict, unsigned)
module comparator_4bit (
  input  logic a0,
  input  logic a1,
  input  logic a2,
  input  logic a3,
  input  logic b0,
  input  logic b1,
  input  logic b2,
  input  logic b3,
  output logic a_greater_b
);

  logic gt0, gt1, gt2, gt3;
  logic eq1, eq2, eq3;

  assign gt3 = a3 & ~b3;
  assign gt2 = a2 & ~b2;
  assign gt1 = a1 & ~b1;
  assign gt0 = a0 & ~b0;

  assign eq3 = ~(a3 ^ b3);
  assign eq2 = ~(a2 ^ b2);
  assign eq1 = ~(a1 ^ b1);

  // MSB-first cascade: a lower bit decides only when all higher bits match.
  assign a_greater_b = gt3
                     | (eq3 & gt2)
                     | (eq3 & eq2 & gt1)
                     | (eq3 & eq2 & eq1 & gt0);

endmodule : comparator_4bit

// File: rtl/window_max_4bit.sv
// window_max_4bit
// Streaming maximum tracker for 4-bit unsigned samples. Collects WINDOW
// samples over a valid/ready handshake and presents the window maximum and
// the 0-based index of its first occurrence on an output valid/ready handshake.
// Parameters:
//   WINDOW  samples per window (2..16)
//   IDX_W   width of index/count fields, clog2(WINDOW)
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   clear      in   synchronous abort of the current window / held result
//   in_valid   in   in_data is valid
//   in_ready   out  a sample can be accepted this cycle
//   in_data    in   4-bit unsigned sample
//   max_valid  out  window result is presented
//   max_ready  in   downstream accepts the result
//   max_data   out  window maximum
//   max_index  out  position of the first occurrence of the maximum
module window_max_4bit
  import window_max_4bit_pkg::*;
#(
  parameter int unsigned WINDOW = WINDOW_DEFAULT,
  parameter int unsigned IDX_W  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SAMPLE_W-1:0] in_data,
  output logic                max_valid,
  input  logic                max_ready,
  output logic [SAMPLE_W-1:0] max_data,
  output logic [IDX_W-1:0]    max_index
);

  state_t              state;
  logic [IDX_W-1:0]    cnt;
  logic [IDX_W-1:0]    cur_idx;
  logic [SAMPLE_W-1:0] cur_max;

  logic a_greater_b;
  logic accept;
  logic last;

  comparator_4bit u_cmp (
    .a0          (in_data[0]),
    .a1          (in_data[1]),
    .a2          (in_data[2]),
    .a3          (in_data[3]),
    .b0          (cur_max[0]),
    .b1          (cur_max[1]),
    .b2          (cur_max[2]),
    .b3          (cur_max[3]),
    .a_greater_b (a_greater_b)
  );

  // Handshake outputs depend on state only, never on in_valid / max_ready.
  assign in_ready  = (state == ST_ACCUM);
  assign max_valid = (state == ST_HOLD);

  // Running registers double as the result registers; they are frozen in HOLD.
  assign max_data  = cur_max;
  assign max_index = cur_idx;

  // clear outranks the input handshake, so a sample offered with it is dropped.
  assign accept = in_valid && in_ready && !clear;
  assign last   = (cnt == IDX_W'(WINDOW - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_ACCUM;
      cnt     <= '0;
      cur_max <= '0;
      cur_idx <= '0;
    end else if (clear) begin
      state <= ST_ACCUM;
      cnt   <= '0;
    end else begin
      unique case (state)
        ST_ACCUM: begin
          if (accept) begin
            if (cnt == '0) begin
              cur_max <= in_data;
              cur_idx <= '0;
            end else if (a_greater_b) begin
              // Strict compare: ties keep the earlier index.
              cur_max <= in_data;
              cur_idx <= cnt;
            end
            if (last) begin
              cnt   <= '0;
              state <= ST_HOLD;
            end else begin
              cnt <= cnt + IDX_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (max_ready) begin
            state <= ST_ACCUM;
          end
        end
        default: state <= ST_ACCUM;
      endcase
    end
  end

endmodule : window_max_4bit

// File: tb/tb_window_max_4bit.sv
module tb_window_max_4bit;

  localparam int WINDOW = 8;
  localparam int IDX_W  = 3;

  logic             clk;
  logic             rst_n;
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_data;
  logic             max_valid;
  logic             max_ready;
  logic [3:0]       max_data;
  logic [IDX_W-1:0] max_index;

  int total = 0;
  int bad   = 0;

  logic [3:0] vec [WINDOW];

  window_max_4bit #(
    .WINDOW (WINDOW),
    .IDX_W  (IDX_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .max_valid (max_valid),
    .max_ready (max_ready),
    .max_data  (max_data),
    .max_index (max_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collects the accepted samples of the current window and,
  // once the window is full, scans them for the first maximum.
  int unsigned win_q [$];
  bit          m_hold;
  int unsigned m_data;
  int unsigned m_idx;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q.delete();
      m_hold = 1'b0;
      m_data = 0;
      m_idx  = 0;
    end else if (clear) begin
      win_q.delete();
      m_hold = 1'b0;
    end else if (!m_hold) begin
      if (in_valid) begin
        win_q.push_back(int'(in_data));
        if (win_q.size() == WINDOW) begin
          m_data = win_q[0];
          m_idx  = 0;
          for (int j = 1; j < WINDOW; j++) begin
            if (win_q[j] > m_data) begin
              m_data = win_q[j];
              m_idx  = j;
            end
          end
          m_hold = 1'b1;
          win_q.delete();
        end
      end
    end else if (max_ready) begin
      m_hold = 1'b0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("mdl_in_ready", in_ready, !m_hold);
    check("mdl_max_valid", max_valid, m_hold);
    if (m_hold) begin
      check("mdl_max_data", max_data, m_data);
      check("mdl_max_index", max_index, m_idx);
    end
    if (!rst_n) begin
      check("mdl_rst_data", max_data, 0);
      check("mdl_rst_index", max_index, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feed vec back-to-back, then check the presented result one cycle later.
  task automatic run_window(input string name, input int exp_d, input int exp_i);
    for (int i = 0; i < WINDOW; i++) begin
      in_valid = 1'b1;
      in_data  = vec[i];
      tick();
    end
    in_valid = 1'b0;
    in_data  = 4'd0;
    check({name, "_valid"}, max_valid, 1);
    check({name, "_data"}, max_data, exp_d);
    check({name, "_index"}, max_index, exp_i);
  endtask

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'd0;
    max_ready = 1'b1;

    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_max_valid", max_valid, 0);
    check("rst_max_data", max_data, 0);
    check("rst_max_index", max_index, 0);
    #10 rst_n = 1'b1;
    tick();

    // Basic window, tie keeps index 1, HOLD lasts a single cycle.
    vec = '{4'd3, 4'd9, 4'd2, 4'd9, 4'd5, 4'd1, 4'd0, 4'd7};
    run_window("basic", 9, 1);
    tick();
    check("basic_one_cycle", max_valid, 0);
    check("basic_ready_back", in_ready, 1);

    // Extremes.
    vec = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd15};
    run_window("last_max", 15, 7);
    tick();
    vec = '{4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4};
    run_window("all_equal", 4, 0);
    tick();
    vec = '{4'd15, 4'd3, 4'd15, 4'd0, 4'd14, 4'd15, 4'd1, 4'd2};
    run_window("first_max", 15, 0);
    tick();

    // Backpressure: result held stable for 5 cycles.
    max_ready = 1'b0;
    vec = '{4'd5, 4'd2, 4'd11, 4'd11, 4'd3, 4'd0, 4'd7, 4'd1};
    run_window("bp", 11, 2);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = 4'd15;
      tick();
      check("bp_in_ready", in_ready, 0);
      check("bp_valid", max_valid, 1);
      check("bp_data", max_data, 11);
      check("bp_index", max_index, 2);
    end
    in_valid  = 1'b0;
    max_ready = 1'b1;
    tick();
    check("bp_release_ready", in_ready, 1);
    check("bp_release_valid", max_valid, 0);
    vec = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd0};
    run_window("bp_fresh", 7, 6);
    tick();

    // Input gaps: samples 1..8 with junk on idle cycles.
    begin
      int sent = 0;
      int guard = 0;
      while (sent < WINDOW && guard < 200) begin
        if ($urandom_range(0, 1) == 1) begin
          in_valid = 1'b1;
          in_data  = 4'(sent + 1);
          sent++;
        end else begin
          in_valid = 1'b0;
          in_data  = 4'd15;
        end
        tick();
        guard++;
      end
      in_valid = 1'b0;
      in_data  = 4'd0;
      check("gaps_sent_all", sent, WINDOW);
      check("gaps_valid", max_valid, 1);
      check("gaps_data", max_data, 8);
      check("gaps_index", max_index, 7);
      tick();
    end

    // Clear mid-window: the sample offered with clear is dropped.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 4'd14;
      tick();
    end
    clear   = 1'b1;
    in_data = 4'd15;
    tick();
    clear = 1'b0;
    check("clr_ready", in_ready, 1);
    vec = '{4'd2, 4'd6, 4'd3, 4'd1, 4'd0, 4'd5, 4'd4, 4'd1};
    run_window("clr_win", 6, 1);
    tick();

    // Clear while holding a result.
    max_ready = 1'b0;
    vec = '{4'd8, 4'd8, 4'd9, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
    run_window("clr_hold_pre", 9, 2);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_hold_valid", max_valid, 0);
    check("clr_hold_ready", in_ready, 1);
    max_ready = 1'b1;
    vec = '{4'd3, 4'd10, 4'd2, 4'd12, 4'd12, 4'd0, 4'd1, 4'd5};
    run_window("clr_hold_after", 12, 3);
    tick();

    // Async reset mid-window, off the clock edge.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 4'd13;
      tick();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_win_ready", in_ready, 1);
    check("arst_win_valid", max_valid, 0);
    check("arst_win_data", max_data, 0);
    check("arst_win_index", max_index, 0);
    #3 rst_n = 1'b1;
    tick();
    check("arst_win_first_edge", in_ready, 1);
    vec = '{4'd2, 4'd1, 4'd0, 4'd3, 4'd1, 4'd2, 4'd0, 4'd1};
    run_window("arst_win_after", 3, 3);
    tick();

    // Async reset while holding a result.
    max_ready = 1'b0;
    vec = '{4'd7, 4'd9, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
    run_window("arst_hold_pre", 9, 1);
    #3 rst_n = 1'b0;
    #1;
    check("arst_hold_ready", in_ready, 1);
    check("arst_hold_valid", max_valid, 0);
    check("arst_hold_data", max_data, 0);
    check("arst_hold_index", max_index, 0);
    #2 rst_n = 1'b1;
    max_ready = 1'b1;
    tick();
    check("arst_hold_first_edge", in_ready, 1);
    vec = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd1};
    run_window("arst_hold_after", 2, 6);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_window_max_4bit
